// File: rtl/ps2_key_decoder.sv
// PS/2 Set 2 scancode decoder: strips E0/F0 prefixes, tracks Shift/Ctrl,
// and queues completed key events in a small FIFO popped by the CPU.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       code_in,
    input  logic             sel,
    input  logic             clr_ovf,
    output logic [11:0]      ev_data,
    output logic             ev_valid,
    output logic             ovf,
    output logic [PTR_W:0]   fifo_cnt
);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_LSHFT = 8'h12;
    localparam logic [7:0] CODE_RSHFT = 8'h59;
    localparam logic [7:0] CODE_CTRL  = 8'h14;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              valid_prev_q;
    logic              lshift_q, lshift_d;
    logic              rshift_q, rshift_d;
    logic              lctrl_q, lctrl_d;
    logic              rctrl_q, rctrl_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [11:0]       mem [FIFO_DEPTH];

    logic              accept;
    logic [7:0]        scan_byte;
    logic              is_prefix;
    logic              is_discard;
    logic              ev_push;
    logic              ev_brk;
    logic              ev_ext;
    logic [11:0]       ev_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              wr_en;

    // Rising edge of the valid bit marks a new byte; held levels are ignored.
    assign accept     = code_in[8] & ~valid_prev_q;
    assign scan_byte  = code_in[7:0];
    assign is_prefix  = (scan_byte == CODE_EXT) || (scan_byte == CODE_BRK);
    assign is_discard = (scan_byte == 8'hAA) || (scan_byte == 8'hFA) ||
                        (scan_byte == 8'hEE) || (scan_byte == 8'h00) ||
                        (scan_byte == 8'hFF);

    always_comb begin
        state_d  = state_q;
        ev_push  = 1'b0;
        ev_brk   = 1'b0;
        ev_ext   = 1'b0;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        lctrl_d  = lctrl_q;
        rctrl_d  = rctrl_q;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (scan_byte == CODE_EXT) begin
                        state_d = EXT;
                    end else if (scan_byte == CODE_BRK) begin
                        state_d = BRK;
                    end else if (!is_discard) begin
                        ev_push = 1'b1;
                    end
                end
                EXT: begin
                    if (scan_byte == CODE_BRK) begin
                        state_d = EXT_BRK;
                    end else if (scan_byte != CODE_EXT) begin
                        ev_push = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    if (!is_prefix) begin
                        ev_push = 1'b1;
                        ev_brk  = 1'b1;
                    end
                end
                EXT_BRK: begin
                    state_d = IDLE;
                    if (!is_prefix) begin
                        ev_push = 1'b1;
                        ev_brk  = 1'b1;
                        ev_ext  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Modifiers follow every completed event, even one the FIFO drops.
        if (ev_push) begin
            if (!ev_ext && scan_byte == CODE_LSHFT) lshift_d = ~ev_brk;
            if (!ev_ext && scan_byte == CODE_RSHFT) rshift_d = ~ev_brk;
            if (!ev_ext && scan_byte == CODE_CTRL)  lctrl_d  = ~ev_brk;
            if (ev_ext  && scan_byte == CODE_CTRL)  rctrl_d  = ~ev_brk;
        end
    end

    assign ev_word = {ev_brk, ev_ext, lshift_d | rshift_d, lctrl_d | rctrl_d, scan_byte};

    assign fifo_full  = (cnt_q == DEPTH_C);
    assign fifo_empty = (cnt_q == '0);
    assign pop        = sel & ~fifo_empty;
    // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
    assign wr_en      = ev_push & (~fifo_full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(pop);

        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (ev_push && !wr_en) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            valid_prev_q <= 1'b0;
            lshift_q     <= 1'b0;
            rshift_q     <= 1'b0;
            lctrl_q      <= 1'b0;
            rctrl_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_prev_q <= code_in[8];
            lshift_q     <= lshift_d;
            rshift_q     <= rshift_d;
            lctrl_q      <= lctrl_d;
            rctrl_q      <= rctrl_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    // Storage carries no reset; the output mux hides stale entries while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= ev_word;
        end
    end

    assign ev_data  = fifo_empty ? 12'h000 : mem[rd_ptr_q];
    assign ev_valid = ~fifo_empty;
    assign ovf      = ovf_q;
    assign fifo_cnt = cnt_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder.
module tb_ps2_key_decoder;

    logic        clk;
    logic        rst;
    logic [8:0]  code_in;
    logic        sel;
    logic        clr_ovf;
    logic [11:0] ev_data;
    logic        ev_valid;
    logic        ovf;
    logic [3:0]  fifo_cnt;

    int checks;
    int errors;

    ps2_key_decoder #(.FIFO_DEPTH(8), .PTR_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .code_in  (code_in),
        .sel      (sel),
        .clr_ovf  (clr_ovf),
        .ev_data  (ev_data),
        .ev_valid (ev_valid),
        .ovf      (ovf),
        .fifo_cnt (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        code_in = {1'b1, b};
        @(negedge clk);
        code_in = {1'b0, b};
        $display("send byte %h -> cnt=%0d", b, fifo_cnt);
    endtask

    task automatic pop_event(input logic [11:0] exp, input string name);
        @(negedge clk);
        checks++;
        if (ev_data !== exp || ev_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: ev_data=%h ev_valid=%b, required %h valid 1", name, ev_data, ev_valid, exp);
        end
        sel = 1'b1;
        @(negedge clk);
        sel = 1'b0;
        $display("pop event %h (%s)", exp, name);
    endtask

    task automatic test_reset;
        rst = 1'b1; code_in = '0; sel = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (fifo_cnt !== 4'd0 || ev_valid !== 1'b0 || ovf !== 1'b0 || ev_data !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d valid=%b ovf=%b data=%h, required 0 0 0 000", fifo_cnt, ev_valid, ovf, ev_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_make_break;
        send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
        checks++;
        if (fifo_cnt !== 4'd2) begin
            errors++;
            $display("FAIL mb_count: cnt=%0d, required 2", fifo_cnt);
        end
        pop_event(12'h01C, "mb_make");
        pop_event(12'h81C, "mb_break");
        checks++;
        if (ev_valid !== 1'b0 || fifo_cnt !== 4'd0) begin
            errors++;
            $display("FAIL mb_empty: valid=%b cnt=%0d, required 0 0", ev_valid, fifo_cnt);
        end
    endtask

    task automatic test_extended;
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        checks++;
        if (fifo_cnt !== 4'd2) begin
            errors++;
            $display("FAIL ext_count: cnt=%0d, required 2", fifo_cnt);
        end
        pop_event(12'h475, "ext_make");
        pop_event(12'hC75, "ext_break");
    endtask

    task automatic test_modifiers;
        send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12);
        checks++;
        if (fifo_cnt !== 4'd3) begin
            errors++;
            $display("FAIL mod_count: cnt=%0d, required 3", fifo_cnt);
        end
        pop_event(12'h212, "lshift_make");
        pop_event(12'h21C, "shifted_key");
        pop_event(12'h812, "lshift_break");
        send_byte(8'hE0); send_byte(8'h14);
        pop_event(12'h514, "rctrl_make");
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
        pop_event(12'hC14, "rctrl_break");
    endtask

    task automatic test_held_valid;
        @(negedge clk);
        code_in = {1'b1, 8'h2A};
        repeat (5) @(negedge clk);
        code_in = {1'b0, 8'h2A};
        @(negedge clk);
        checks++;
        if (fifo_cnt !== 4'd1) begin
            errors++;
            $display("FAIL held_valid_count: cnt=%0d, required 1", fifo_cnt);
        end
        pop_event(12'h02A, "held_valid");
        send_byte(8'hAA); send_byte(8'hFA);
        checks++;
        if (fifo_cnt !== 4'd0 || ev_valid !== 1'b0) begin
            errors++;
            $display("FAIL discard_codes: cnt=%0d valid=%b, required 0 0", fifo_cnt, ev_valid);
        end
        send_byte(8'hF0); send_byte(8'hF0); send_byte(8'h1C);
        checks++;
        if (fifo_cnt !== 4'd1) begin
            errors++;
            $display("FAIL double_break_count: cnt=%0d, required 1", fifo_cnt);
        end
        pop_event(12'h01C, "double_break_recover");
    endtask

    task automatic test_overflow;
        logic [7:0] codes [9];
        codes = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B};
        for (int i = 0; i < 9; i++) send_byte(codes[i]);
        checks++;
        if (fifo_cnt !== 4'd8 || ovf !== 1'b1 || ev_data !== 12'h01C) begin
            errors++;
            $display("FAIL ovf_full: cnt=%0d ovf=%b head=%h, required 8 1 01C", fifo_cnt, ovf, ev_data);
        end
        // push and pop together while full
        @(negedge clk);
        code_in = {1'b1, 8'h21}; sel = 1'b1;
        @(negedge clk);
        code_in = {1'b0, 8'h21}; sel = 1'b0;
        checks++;
        if (fifo_cnt !== 4'd8 || ev_data !== 12'h01B) begin
            errors++;
            $display("FAIL full_push_pop: cnt=%0d head=%h, required 8 01B", fifo_cnt, ev_data);
        end
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0 || fifo_cnt !== 4'd8) begin
            errors++;
            $display("FAIL clr_ovf: ovf=%b cnt=%0d, required 0 8", ovf, fifo_cnt);
        end
        // overflow coinciding with clear: set wins
        @(negedge clk);
        code_in = {1'b1, 8'h29}; clr_ovf = 1'b1;
        @(negedge clk);
        code_in = {1'b0, 8'h29}; clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b1 || fifo_cnt !== 4'd8 || ev_data !== 12'h01B) begin
            errors++;
            $display("FAIL ovf_set_wins: ovf=%b cnt=%0d head=%h, required 1 8 01B", ovf, fifo_cnt, ev_data);
        end
        pop_event(12'h01B, "drain0");
        pop_event(12'h023, "drain1");
        pop_event(12'h02B, "drain2");
        pop_event(12'h034, "drain3");
        pop_event(12'h033, "drain4");
        pop_event(12'h03B, "drain5");
        pop_event(12'h042, "drain6");
        pop_event(12'h021, "drain7_wrapped");
        @(negedge clk);
        sel = 1'b1;
        @(negedge clk);
        sel = 1'b0;
        checks++;
        if (fifo_cnt !== 4'd0 || ev_valid !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL pop_empty: cnt=%0d valid=%b ovf=%b, required 0 0 1", fifo_cnt, ev_valid, ovf);
        end
    endtask

    task automatic test_reset_mid;
        send_byte(8'h1C);
        send_byte(8'hE0); send_byte(8'hF0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_cnt !== 4'd0 || ev_valid !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: cnt=%0d valid=%b ovf=%b, required 0 0 0", fifo_cnt, ev_valid, ovf);
        end
        rst = 1'b0;
        send_byte(8'h1C);
        checks++;
        if (fifo_cnt !== 4'd1) begin
            errors++;
            $display("FAIL post_reset_count: cnt=%0d, required 1", fifo_cnt);
        end
        pop_event(12'h01C, "post_reset_make");
        // valid already high as reset releases counts as a fresh byte
        @(negedge clk);
        rst = 1'b1; code_in = {1'b1, 8'h29};
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        code_in = {1'b0, 8'h29};
        @(negedge clk);
        checks++;
        if (fifo_cnt !== 4'd1) begin
            errors++;
            $display("FAIL valid_at_release_count: cnt=%0d, required 1", fifo_cnt);
        end
        pop_event(12'h029, "valid_at_release");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_make_break;
        test_extended;
        test_modifiers;
        test_held_valid;
        test_overflow;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
